// File: rtl/alu16_arbiter_pkg.sv
// Shared opcode and FSM state definitions for the alu16_arbiter block
// and its testbench.
package alu16_arbiter_pkg;

   localparam logic OP_AND = 1'b0;
   localparam logic OP_ADD = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu16_core.sv
// Combinational AND/ADD datapath shared by both requesters; ADD wraps
// modulo 2^WIDTH with the carry-out dropped.
module alu16_core
   import alu16_arbiter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] out
);

   assign out = (op == OP_ADD) ? a + b : a & b;

endmodule

// File: rtl/alu16_arbiter.sv
// Two-requester round-robin front end time-sharing one alu16_core through
// an IDLE -> EXEC -> RESP sequence, one operation in flight at a time.
module alu16_arbiter
   import alu16_arbiter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [1:0]         req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic [1:0]         resp_valid,
   input  logic [1:0]         resp_ready,
   output logic [WIDTH-1:0]   resp_data,
   output logic               busy
);

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             id_q, id_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic             win;
   logic [WIDTH-1:0] alu_out;

   alu16_core #(.WIDTH(WIDTH)) u_core (
      .a   (a_q),
      .b   (b_q),
      .op  (op_q),
      .out (alu_out)
   );

   // With both requesters valid the one that did not win last time goes next.
   always_comb begin
      case (req_valid)
         2'b10:   win = 1'b1;
         2'b11:   win = ~last_grant_q;
         default: win = 1'b0;
      endcase
   end

   assign req_ready  = (state_q == ST_IDLE && !reset && |req_valid)
                       ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign resp_valid = (state_q == ST_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
   assign resp_data  = resp_data_q;
   assign busy       = (state_q != ST_IDLE);

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves one unassigned and infers a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      resp_data_d  = resp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (|(req_valid & req_ready)) begin
               id_d         = win;
               last_grant_d = win;
               op_d         = req_op[win];
               a_d          = win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
               b_d          = win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            resp_data_d = alu_out;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready[id_q]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: last_grant resets to 1 so requester 0 wins the first contended round.
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         op_q         <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         resp_data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         resp_data_q  <= resp_data_d;
      end
   end

endmodule
